// File: rtl/prog_mem.sv
// prog_mem: loadable program memory for the fetch stage.
// One-cycle registered fetch port with out-of-range detection, plus a
// streaming loader that rewrites the array and pads the tail with FILL_WORD.
module prog_mem #(
  parameter int unsigned            WIDTH     = 16,
  parameter int unsigned            DEPTH     = 64,
  parameter int unsigned            ADDR_W    = 8,
  parameter logic [WIDTH-1:0]       FILL_WORD = 16'hBF00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic [WIDTH-1:0]  instr,
  output logic              instr_valid,
  output logic              oob,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {RUN, LOAD, PAD, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] wp;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             in_range;

  // Storage is not touched by reset; it powers up holding the fill word.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: FILL_WORD};

  // Write port: loader handshakes in LOAD, fill word every cycle in PAD.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = FILL_WORD;
    if (state == LOAD && load_valid) begin
      wr_en   = 1'b1;
      wr_data = load_data;
    end else if (state == PAD) begin
      wr_en   = 1'b1;
    end
  end

  // Array write; no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wp         <= '0;
      load_count <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            wp         <= '0;
            load_count <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wp         <= wp + 1'b1;
            load_count <= load_count + 1'b1;
            // Final slot wins over load_last: nothing left to pad.
            if (wp == LAST_IDX) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else if (load_last) begin
              state      <= PAD;
              load_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          wp <= wp + 1'b1;
          if (wp == LAST_IDX) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
        end
        DONE: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_range = (32'(pc) < 32'(DEPTH));

  // Fetch port: accepted only in RUN, one-cycle registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= FILL_WORD;
      instr_valid <= 1'b0;
      oob         <= 1'b0;
    end else if (fetch_en && state == RUN) begin
      instr_valid <= 1'b1;
      if (in_range) begin
        instr <= mem[pc[IDX_W-1:0]];
        oob   <= 1'b0;
      end else begin
        instr <= FILL_WORD;
        oob   <= 1'b1;
      end
    end else begin
      instr_valid <= 1'b0;
      oob         <= 1'b0;
    end
  end

endmodule
